fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode/execute datapath (register bank, ULA, control).
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Holds the returned instruction in an instruction register and presents it, with pre-split fields, to downstream through a valid/ready handshake.
- Handles PC redirects and the end-of-execution halt from the control unit.

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_stage_inst_field_split.sv | 17 +
 rtl/fetch_stage.sv | 188 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and decode: instruction field layout and FSM states.
package fetch_stage_pkg;

  localparam int unsigned INST_W      = 32;
  localparam int unsigned PC_STEP_DEF = 4;

  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned REG1_MSB = 23;
  localparam int unsigned REG1_LSB = 20;
  localparam int unsigned REG2_MSB = 19;
  localparam int unsigned REG2_LSB = 16;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned IMM_LSB  = 0;

  localparam int unsigned OPC_W  = OPC_MSB - OPC_LSB + 1;
  localparam int unsigned REG_W  = REG1_MSB - REG1_LSB + 1;
  localparam int unsigned IMM_W  = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_inst_field_split.sv
// Combinational split of an instruction word into opcode / reg1 / reg2 / imm.
module inst_field_split
  import fetch_stage_pkg::*;
(
  input  logic [INST_W-1:0] inst_i,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [REG_W-1:0]  reg1_o,
  output logic [REG_W-1:0]  reg2_o,
  output logic [IMM_W-1:0]  imm_o
);

  assign opcode_o = inst_i[OPC_MSB:OPC_LSB];
  assign reg1_o   = inst_i[REG1_MSB:REG1_LSB];
  assign reg2_o   = inst_i[REG2_MSB:REG2_LSB];
  assign imm_o    = inst_i[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads memory over req/ack, and hands one instruction
// at a time downstream over valid/ready, with redirect and halt from control.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_W-1:0]  reg1,
  output logic [REG_W-1:0]  reg2,
  output logic [IMM_W-1:0]  imm,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              discard_q, discard_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]       count_q, count_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] redir_tgt;

  assign redir_tgt = redirect_pc & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      count_q   <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      count_q   <= count_d;
      halted_q  <= halted_d;
    end
  end

  // Next-state: halt > redirect > handshake. mem_addr is latched per request so a
  // redirect during an outstanding read only retargets the PC, not the bus.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    req_d     = req_q;
    discard_d = discard_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    count_d   = count_q;
    halted_d  = halted_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_REQ;
          pc_d      = RESET_PC;
          addr_d    = RESET_PC;
          req_d     = 1'b1;
          discard_d = 1'b0;
        end
      end

      ST_REQ: begin
        if (halt) begin
          state_d   = ST_HALTED;
          req_d     = 1'b0;
          valid_d   = 1'b0;
          discard_d = 1'b0;
          halted_d  = 1'b1;
        end else if (req_q && mem_ack) begin
          if (discard_q) begin
            discard_d = 1'b0;
            req_d     = 1'b0;
            if (redirect_valid) pc_d = redir_tgt;
          end else if (redirect_valid) begin
            pc_d   = redir_tgt;
            addr_d = redir_tgt;
            req_d  = 1'b1;
          end else begin
            inst_d    = mem_rdata;
            inst_pc_d = addr_q;
            pc_d      = addr_q + ADDR_W'(PC_STEP);
            valid_d   = 1'b1;
            req_d     = 1'b0;
            state_d   = ST_HOLD;
          end
        end else if (req_q) begin
          if (redirect_valid) begin
            pc_d      = redir_tgt;
            discard_d = 1'b1;
          end
        end else begin
          // Idle gap after a dropped read: issue the next request from the current PC.
          pc_d   = redirect_valid ? redir_tgt : pc_q;
          addr_d = redirect_valid ? redir_tgt : pc_q;
          req_d  = 1'b1;
        end
      end

      ST_HOLD: begin
        if (halt) begin
          if (inst_ready) count_d = count_q + 32'd1;
          state_d   = ST_HALTED;
          req_d     = 1'b0;
          valid_d   = 1'b0;
          discard_d = 1'b0;
          halted_d  = 1'b1;
        end else if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redir_tgt;
          addr_d  = redir_tgt;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else if (inst_ready) begin
          count_d = count_q + 32'd1;
          valid_d = 1'b0;
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_HALTED: begin
        if (start && !halt) begin
          state_d   = ST_REQ;
          pc_d      = RESET_PC;
          addr_d    = RESET_PC;
          req_d     = 1'b1;
          discard_d = 1'b0;
          halted_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign inst_valid  = valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

  inst_field_split u_split (
    .inst_i   (inst_q),
    .opcode_o (opcode),
    .reg1_o   (reg1),
    .reg2_o   (reg2),
    .imm_o    (imm)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: table of sequential fetches plus corner sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, start, mem_req, mem_ack, inst_valid, inst_ready;
  logic        redirect_valid, halt, halted;
  logic [31:0] mem_addr, mem_rdata, inst, inst_pc, redirect_pc, fetch_count;
  logic [7:0]  opcode;
  logic [3:0]  reg1, reg2;
  logic [15:0] imm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .opcode(opcode), .reg1(reg1), .reg2(reg2), .imm(imm), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .fetch_count(fetch_count)
  );

  typedef struct {
    logic [31:0] word;
    logic [7:0]  opc;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [15:0] imm;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!mem_req) begin
      errors++;
      $display("FAIL wait_req: mem_req got 0 expected 1 within 50 cycles");
    end
  endtask

  // Wait for a request, check its address, ack after lat cycles with word.
  task automatic mem_serve(input logic [31:0] word, input int lat, input logic [31:0] exp_addr);
    wait_req();
    chk("req_addr", mem_addr, exp_addr);
    repeat (lat) tick();
    chk("req_addr_held", mem_addr, exp_addr);
    mem_ack   = 1'b1;
    mem_rdata = word;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    vecs[0] = '{32'h0110_0005, 8'h01, 4'h1, 4'h0, 16'h0005, 32'h00};
    vecs[1] = '{32'h0223_0000, 8'h02, 4'h2, 4'h3, 16'h0000, 32'h04};
    vecs[2] = '{32'hFFAB_1234, 8'hFF, 4'hA, 4'hB, 16'h1234, 32'h08};
    vecs[3] = '{32'h7E9C_8001, 8'h7E, 4'h9, 4'hC, 16'h8001, 32'h0C};

    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_outputs();

    // Sequential fetch, ready always high, 1-cycle memory latency
    inst_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_serve(vecs[i].word, 1, vecs[i].pc);
      chk("valid", 32'(inst_valid), 32'd1);
      chk("inst", inst, vecs[i].word);
      chk("opcode", 32'(opcode), 32'(vecs[i].opc));
      chk("reg1", 32'(reg1), 32'(vecs[i].r1));
      chk("reg2", 32'(reg2), 32'(vecs[i].r2));
      chk("imm", 32'(imm), 32'(vecs[i].imm));
      chk("inst_pc", inst_pc, vecs[i].pc);
      chk("count_before", fetch_count, 32'(i));
    end
    tick();
    chk("count_after_table", fetch_count, 32'd4);
    chk("valid_after_hs", 32'(inst_valid), 32'd0);

    // Back-pressure: ready low 5 cycles, 3-cycle memory latency
    inst_ready = 1'b0;
    mem_serve(32'h0A0B_0C0D, 3, 32'h10);
    held = inst;
    chk("bp_inst", held, 32'h0A0B_0C0D);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", inst, 32'h0A0B_0C0D);
      chk("bp_valid", 32'(inst_valid), 32'd1);
      chk("bp_no_req", 32'(mem_req), 32'd0);
      chk("bp_count", fetch_count, 32'd4);
    end
    inst_ready = 1'b1;
    tick();
    chk("bp_count_done", fetch_count, 32'd5);
    chk("bp_next_req", 32'(mem_req), 32'd1);
    chk("bp_next_addr", mem_addr, 32'h14);

    // Redirect while a read is outstanding: returned word must be dropped
    redirect_valid = 1'b1; redirect_pc = 32'h40; tick(); redirect_valid = 1'b0;
    chk("rd_addr_held", mem_addr, 32'h14);
    chk("rd_req_held", 32'(mem_req), 32'd1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_ack = 1'b0;
    chk("rd_gap_req", 32'(mem_req), 32'd0);
    chk("rd_gap_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("rd_valid_after", 32'(inst_valid), 32'd0);
    mem_serve(32'h1122_3344, 1, 32'h40);
    chk("rd_new_inst", inst, 32'h1122_3344);
    chk("rd_new_pc", inst_pc, 32'h40);
    chk("rd_count", fetch_count, 32'd5);

    // Redirect in HOLD with ready high: instruction dropped, target aligned
    redirect_valid = 1'b1; redirect_pc = 32'h23; tick(); redirect_valid = 1'b0;
    chk("rh_valid", 32'(inst_valid), 32'd0);
    chk("rh_count", fetch_count, 32'd5);
    chk("rh_req", 32'(mem_req), 32'd1);
    chk("rh_addr", mem_addr, 32'h20);

    // Halt during an outstanding read, then a late ack
    halt = 1'b1; tick(); halt = 1'b0;
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_req", 32'(mem_req), 32'd0);
    chk("h_valid", 32'(inst_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055; tick(); mem_ack = 1'b0;
    chk("h_late_valid", 32'(inst_valid), 32'd0);
    chk("h_late_req", 32'(mem_req), 32'd0);
    chk("h_late_count", fetch_count, 32'd5);
    halt = 1'b1; start = 1'b1; tick(); halt = 1'b0; start = 1'b0;
    chk("h_start_halt", 32'(halted), 32'd1);
    chk("h_start_halt_req", 32'(mem_req), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("h_restart_halted", 32'(halted), 32'd0);
    chk("h_restart_req", 32'(mem_req), 32'd1);
    chk("h_restart_addr", mem_addr, 32'h0);

    // Halt together with a handshake still counts the instruction
    mem_serve(32'h0000_0099, 1, 32'h0);
    halt = 1'b1; tick(); halt = 1'b0;
    chk("hh_count", fetch_count, 32'd6);
    chk("hh_halted", 32'(halted), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("hh_restart_addr", mem_addr, 32'h0);

    // Reset mid-read with ack in the same cycle, then a late ack in IDLE
    wait_req();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678; tick();
    rst = 1'b0; mem_ack = 1'b0;
    chk_reset_outputs();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678; tick(); mem_ack = 1'b0;
    tick();
    chk("idle_late_valid", 32'(inst_valid), 32'd0);
    chk("idle_late_req", 32'(mem_req), 32'd0);
    chk("idle_late_inst", inst, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
